mul_seq_digit: RTL and testbench

- Sequential WIDTH x WIDTH unsigned multiplier built around a single combinational 2x2 digit multiplier.
- Splits both operands into 2-bit digits and feeds one digit pair per cycle to the digit multiplier.
- Shifts each 4-bit partial product into a 2*WIDTH-bit accumulator.
- Sits between the operand source (start/a/b) and result consumers; trades latency for area versus a full array multiplier.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_seq_digit_if.sv | 27 ++
 rtl/digit_mul2x2.sv | 25 ++
 rtl/mul_seq_digit.sv | 118 +++++++++++
 tb/tb_mul_seq_digit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the digit-serial multiplier: digit width, FSM states
// and the index-counter width helper.
package mul_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_seq_digit_if.sv
// Operand/result bundle between the operand source, the multiplier and the
// result consumer.
interface mul_seq_digit_if #(
  parameter int WIDTH = 8
);

  // Handshake: start is accepted on a rising edge where busy=0 (a/b are
  // captured then); done pulses high for one cycle while product is valid,
  // and product holds until the next completion or reset.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/digit_mul2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier built from two half adders.
module digit_mul2x2 (
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic [3:0] p_o
);

  logic pp00, pp01, pp10, pp11;
  logic c1, c2;

  always_comb begin
    pp00 = x_i[0] & y_i[0];
    pp01 = x_i[0] & y_i[1];
    pp10 = x_i[1] & y_i[0];
    pp11 = x_i[1] & y_i[1];
    // Column 1 half adder, then column 2 half adder absorbing its carry.
    c1     = pp10 & pp01;
    c2     = pp11 & c1;
    p_o[0] = pp00;
    p_o[1] = pp10 ^ pp01;
    p_o[2] = pp11 ^ c1;
    p_o[3] = c2;
  end

endmodule

// File: rtl/mul_seq_digit.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one 2x2 digit product per cycle,
// shifted into a 2*WIDTH-bit accumulator over N*N RUN cycles.
module mul_seq_digit
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  mul_seq_digit_if.slave  bus,
  output state_e          state_o
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int IW = idx_w(N);
  localparam int PW = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [IW-1:0]      i_q, i_d;
  logic [IW-1:0]      j_q, j_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [1:0]         a_dig, b_dig;
  logic [3:0]         pp;
  logic [PW-1:0]      pp_sh;
  logic [PW-1:0]      acc_sum;

  always_comb begin
    a_sh  = a_q >> (DIGIT_W * int'(i_q));
    b_sh  = b_q >> (DIGIT_W * int'(j_q));
    a_dig = a_sh[1:0];
    b_dig = b_sh[1:0];
  end

  digit_mul2x2 u_digit (
    .x_i (a_dig),
    .y_i (b_dig),
    .p_o (pp)
  );

  always_comb begin
    pp_sh   = PW'(pp) << (DIGIT_W * (int'(i_q) + int'(j_q)));
    acc_sum = acc_q + pp_sh;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    i_d     = i_q;
    j_d     = j_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          if (i_q == IW'(N - 1)) begin
            i_d     = '0;
            prod_d  = acc_sum;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      i_q     <= i_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = prod_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mul_seq_digit.sv
// Directed and random checks of mul_seq_digit at WIDTH=8 and WIDTH=2 against
// a plain-arithmetic reference (product = a*b, latency = N*N edges).
module tb_mul_seq_digit;
  import mul_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_seq_digit_if #(.WIDTH(8)) if8 ();
  mul_seq_digit_if #(.WIDTH(2)) if2 ();
  state_e state8, state2;

  mul_seq_digit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8), .state_o(state8));
  mul_seq_digit #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2), .state_o(state2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One WIDTH=8 operation; inj_at >= 0 re-pulses start (a=b=1) while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj_at);
    int edges;
    int busy_cnt;
    logic [15:0] exp_q[$];
    exp_q.push_back(16'(a) * 16'(b));
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    chk("state_run8", 32'(state8), 32'(RUN));
    edges = 0; busy_cnt = 0;
    while (!if8.done && edges < 100) begin
      if (if8.busy) busy_cnt++;
      if (edges == inj_at) begin
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01;
      end else begin
        if8.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    chk("latency8", 32'(edges), 32'd16);
    chk("busy_cycles8", 32'(busy_cnt), 32'd16);
    chk("product8", 32'(if8.product), 32'(exp_q[0]));
    chk("busy_at_done8", 32'(if8.busy), 32'd0);
    @(negedge clk);
    chk("done_pulse8", 32'(if8.done), 32'd0);
    chk("product_hold8", 32'(if8.product), 32'(exp_q.pop_front()));
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    int edges;
    int busy_cnt;
    logic [3:0] exp_p;
    exp_p = 4'(a) * 4'(b);
    @(negedge clk);
    if2.start = 1'b1; if2.a = a; if2.b = b;
    @(posedge clk);
    @(negedge clk);
    if2.start = 1'b0; if2.a = ~a; if2.b = ~b;
    edges = 0; busy_cnt = 0;
    while (!if2.done && edges < 20) begin
      if (if2.busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    chk("latency2", 32'(edges), 32'd1);
    chk("busy_cycles2", 32'(busy_cnt), 32'd1);
    chk($sformatf("product2_%0d_%0d", a, b), 32'(if2.product), 32'(exp_p));
    @(negedge clk);
    chk("done_pulse2", 32'(if2.done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int last;
    int idle_cnt;
    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    chk("rst_done8", 32'(if8.done), 32'd0);
    chk("rst_product8", 32'(if8.product), 32'd0);
    chk("rst_state8", 32'(state8), 32'(IDLE));
    chk("rst_product2", 32'(if2.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operands.
    op8(8'hFF, 8'hFF, -1);
    op8(8'hA5, 8'h5A, -1);
    op8(8'h00, 8'h7C, -1);
    op8(8'h03, 8'h03, -1);

    // start re-pulsed while busy must be ignored.
    op8(8'hFF, 8'hFF, 5);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if8.done) dones++;
    end
    chk("no_extra_done", 32'(dones), 32'd0);
    chk("ignored_product", 32'(if8.product), 32'hFE01);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'hC3; if8.b = 8'h99;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(if8.busy), 32'd0);
    chk("async_done", 32'(if8.done), 32'd0);
    chk("async_product", 32'(if8.product), 32'd0);
    chk("async_state", 32'(state8), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if8.done) dones++;
    end
    chk("no_done_after_rst", 32'(dones), 32'd0);
    op8(8'h12, 8'h34, -1);

    // start held high: back-to-back operations every N*N+1 cycles.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h10;
    dones = 0; last = -1; idle_cnt = 0;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      if (if8.done) begin
        chk("b2b_product", 32'(if8.product), 32'h0100);
        chk("b2b_busy_low", 32'(if8.busy), 32'd0);
        if (last >= 0) chk("b2b_period", 32'(c - last), 32'd17);
        last = c;
        dones++;
      end else if (!if8.busy) begin
        idle_cnt++;
      end
    end
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_idle", 32'(idle_cnt), 32'd0);
    if8.start = 1'b0;
    repeat (20) @(negedge clk);

    // Random operands against a*b.
    for (int k = 0; k < 8; k++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);
    end

    // WIDTH=2 exhaustive sweep.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        op2(2'(x), 2'(y));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
